// File: rtl/baud_generator_frac.sv
// baud_generator_frac: oversampling tick and bit-rate clock from a runtime fractional divisor.
// Tick period averages div_int + div_frac/2^FRAC_WIDTH cycles. A new divisor requested while
// running is shadowed and applied only when the bit counter wraps, keeping o_clk glitch-free.
// Optional legacy baud table: define BAUD_GEN_LEGACY_SELECT_EN to add i_baud_select/i_use_select.
module baud_generator_frac #(
  parameter int unsigned FPGA_CLK   = 100_000_000,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 4,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned RESET_BAUD = 115200
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [DIV_WIDTH-1:0]  i_div_int,
  input  logic [FRAC_WIDTH-1:0] i_div_frac,
  input  logic                  i_update_baud,
`ifdef BAUD_GEN_LEGACY_SELECT_EN
  input  logic [3:0]            i_baud_select,
  input  logic                  i_use_select,
`endif
  output logic                  o_tick,
  output logic                  o_clk,
  output logic                  o_rising_edge,
  output logic                  o_falling_edge,
  output logic                  o_update_pending
);

  localparam int unsigned DivW   = DIV_WIDTH + FRAC_WIDTH;
  localparam int unsigned OsW    = $clog2(OVERSAMPLE);
  localparam int unsigned OsHalf = OVERSAMPLE / 2;

  // Fixed-point divisor for a baud rate: floor(clk * 2^FRAC / (baud * oversample)).
  function automatic logic [DivW-1:0] calc_div(input logic [63:0] baud);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'(FPGA_CLK) << FRAC_WIDTH;
    den = baud * 64'(OVERSAMPLE);
    return DivW'(num / den);
  endfunction

  localparam logic [DivW-1:0]       ResetDiv  = calc_div(64'(RESET_BAUD));
  localparam logic [DIV_WIDTH-1:0]  ResetInt  = ResetDiv[DivW-1 -: DIV_WIDTH];
  localparam logic [FRAC_WIDTH-1:0] ResetFrac = ResetDiv[FRAC_WIDTH-1:0];

  typedef enum logic [1:0] {StIdle, StRun, StPending} state_e;

  state_e                r_state, w_state_nxt;
  logic [DIV_WIDTH-1:0]  r_div_int, w_div_int_nxt;
  logic [FRAC_WIDTH-1:0] r_div_frac, w_div_frac_nxt;
  logic [DIV_WIDTH-1:0]  r_sh_int, w_sh_int_nxt;
  logic [FRAC_WIDTH-1:0] r_sh_frac, w_sh_frac_nxt;
  logic [DIV_WIDTH-1:0]  r_cyc, w_cyc_nxt;
  logic [FRAC_WIDTH-1:0] r_frac_acc, w_acc_nxt;
  logic                  r_carry, w_carry_nxt;
  logic [OsW-1:0]        r_os_cnt, w_os_nxt;
  logic                  r_tick, w_tick_nxt;
  logic                  r_rise, w_rise_nxt;
  logic                  r_fall, w_fall_nxt;

  logic [DIV_WIDTH-1:0]  w_upd_int;
  logic [FRAC_WIDTH-1:0] w_upd_frac;
  logic [DIV_WIDTH-1:0]  w_div_eff;
  logic [DIV_WIDTH:0]    w_period;
  logic                  w_cyc_last;
  logic                  w_wrap;
  logic [OsW-1:0]        w_os_inc;
  logic [FRAC_WIDTH:0]   w_acc_sum;

`ifdef BAUD_GEN_LEGACY_SELECT_EN
  logic [DivW-1:0] w_tbl_div;

  // Legacy rate table; unused codes fall back to 9600 baud.
  always_comb begin
    case (i_baud_select)
      4'd0:    w_tbl_div = calc_div(64'd9600);
      4'd1:    w_tbl_div = calc_div(64'd19200);
      4'd2:    w_tbl_div = calc_div(64'd38400);
      4'd3:    w_tbl_div = calc_div(64'd57600);
      4'd4:    w_tbl_div = calc_div(64'd115200);
      4'd5:    w_tbl_div = calc_div(64'd230400);
      4'd6:    w_tbl_div = calc_div(64'd460800);
      4'd7:    w_tbl_div = calc_div(64'd921600);
      4'd8:    w_tbl_div = calc_div(64'd1000000);
      4'd9:    w_tbl_div = calc_div(64'd1500000);
      default: w_tbl_div = calc_div(64'd9600);
    endcase
  end

  // Requested divisor: table entry or explicit int/frac inputs.
  always_comb begin
    if (i_use_select) begin
      w_upd_int  = w_tbl_div[DivW-1 -: DIV_WIDTH];
      w_upd_frac = w_tbl_div[FRAC_WIDTH-1:0];
    end else begin
      w_upd_int  = i_div_int;
      w_upd_frac = i_div_frac;
    end
  end
`else
  // Requested divisor comes straight from the inputs.
  always_comb begin
    w_upd_int  = i_div_int;
    w_upd_frac = i_div_frac;
  end
`endif

  // Period of the current tick, end-of-period and end-of-bit detection.
  always_comb begin
    w_div_eff  = (r_div_int < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : r_div_int;
    w_period   = {1'b0, w_div_eff} + {{DIV_WIDTH{1'b0}}, r_carry};
    w_cyc_last = ({1'b0, r_cyc} == (w_period - (DIV_WIDTH+1)'(1)));
    w_wrap     = w_cyc_last && (r_os_cnt == OsW'(OVERSAMPLE - 1));
    w_os_inc   = w_wrap ? '0 : r_os_cnt + OsW'(1);
    w_acc_sum  = {1'b0, r_frac_acc} + {1'b0, r_div_frac};
  end

  // Next-state and datapath updates for IDLE / RUN / PENDING.
  always_comb begin
    w_state_nxt    = r_state;
    w_div_int_nxt  = r_div_int;
    w_div_frac_nxt = r_div_frac;
    w_sh_int_nxt   = r_sh_int;
    w_sh_frac_nxt  = r_sh_frac;
    w_cyc_nxt      = r_cyc;
    w_acc_nxt      = r_frac_acc;
    w_carry_nxt    = r_carry;
    w_os_nxt       = r_os_cnt;
    w_tick_nxt     = 1'b0;
    w_rise_nxt     = 1'b0;
    w_fall_nxt     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cyc_nxt   = '0;
        w_acc_nxt   = '0;
        w_carry_nxt = 1'b0;
        w_os_nxt    = '0;
        // No bit in flight, so a new divisor can take effect at once.
        if (i_update_baud) begin
          w_div_int_nxt  = w_upd_int;
          w_div_frac_nxt = w_upd_frac;
        end
        if (i_enable) begin
          w_state_nxt = StRun;
        end
      end
      StRun, StPending: begin
        if (!i_enable) begin
          w_state_nxt = StIdle;
          w_cyc_nxt   = '0;
          w_acc_nxt   = '0;
          w_carry_nxt = 1'b0;
          w_os_nxt    = '0;
          // Leaving RUN: the newest request wins, otherwise flush the shadow.
          if (i_update_baud) begin
            w_div_int_nxt  = w_upd_int;
            w_div_frac_nxt = w_upd_frac;
          end else if (r_state == StPending) begin
            w_div_int_nxt  = r_sh_int;
            w_div_frac_nxt = r_sh_frac;
          end
        end else begin
          if (w_cyc_last) begin
            w_cyc_nxt   = '0;
            w_tick_nxt  = 1'b1;
            w_acc_nxt   = w_acc_sum[FRAC_WIDTH-1:0];
            w_carry_nxt = w_acc_sum[FRAC_WIDTH];
            w_os_nxt    = w_os_inc;
            w_fall_nxt  = w_wrap;
            w_rise_nxt  = (w_os_inc == OsW'(OsHalf));
          end else begin
            w_cyc_nxt = r_cyc + DIV_WIDTH'(1);
          end
          // Bit boundary: swap in the shadow and restart the fractional sequence.
          if (w_wrap && (r_state == StPending)) begin
            w_div_int_nxt  = r_sh_int;
            w_div_frac_nxt = r_sh_frac;
            w_acc_nxt      = '0;
            w_carry_nxt    = 1'b0;
            w_state_nxt    = StRun;
          end
          // A request on the boundary cycle waits for the next boundary.
          if (i_update_baud) begin
            w_sh_int_nxt  = w_upd_int;
            w_sh_frac_nxt = w_upd_frac;
            w_state_nxt   = StPending;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Divisors, counters and registered strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_int  <= ResetInt;
      r_div_frac <= ResetFrac;
      r_sh_int   <= '0;
      r_sh_frac  <= '0;
      r_cyc      <= '0;
      r_frac_acc <= '0;
      r_carry    <= 1'b0;
      r_os_cnt   <= '0;
      r_tick     <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_div_int  <= w_div_int_nxt;
      r_div_frac <= w_div_frac_nxt;
      r_sh_int   <= w_sh_int_nxt;
      r_sh_frac  <= w_sh_frac_nxt;
      r_cyc      <= w_cyc_nxt;
      r_frac_acc <= w_acc_nxt;
      r_carry    <= w_carry_nxt;
      r_os_cnt   <= w_os_nxt;
      r_tick     <= w_tick_nxt;
      r_rise     <= w_rise_nxt;
      r_fall     <= w_fall_nxt;
    end
  end

  assign o_tick           = r_tick;
  assign o_clk            = (r_os_cnt >= OsW'(OsHalf));
  assign o_rising_edge    = r_rise;
  assign o_falling_edge   = r_fall;
  assign o_update_pending = (r_state == StPending);

endmodule
